// File: rtl/adder_result_stage_pkg.sv
// Shared constants and types for the adder result stage: operand width, FIFO depth,
// flag bit positions and the occupancy-derived control state.
package adder_result_stage_pkg;

    localparam int INPUTSIZE         = 8;
    localparam int GROUPSIZE         = 4;
    localparam int RESULT_FIFO_DEPTH = 4;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_ZERO  = 2;

    typedef enum logic [1:0] {
        FIFO_EMPTY,
        FIFO_PARTIAL,
        FIFO_FULL
    } fifo_state_e;

endpackage

// File: rtl/adder_result_stage_flag_gen.sv
// Combinational flag generator for a WIDTH+1-bit adder sum; usable on unbuffered sums too.
module adder_flag_gen
    import adder_result_stage_pkg::*;
#(
    parameter int WIDTH = INPUTSIZE
) (
    input  logic [WIDTH:0] sum_i,
    output logic [2:0]     flags_o
);

    always_comb begin
        flags_o             = '0;
        flags_o[FLAG_CARRY] = sum_i[WIDTH];
        flags_o[FLAG_NEG]   = sum_i[WIDTH-1];
        flags_o[FLAG_ZERO]  = (sum_i[WIDTH-1:0] == '0);
    end

endmodule

// File: rtl/adder_result_stage.sv
// Result FIFO behind the adder: stores {flags, sum} per push and presents the head entry
// through a registered output so the adder path never sees a downstream stall.
module adder_result_stage
    import adder_result_stage_pkg::*;
#(
    parameter int WIDTH = INPUTSIZE,
    parameter int DEPTH = RESULT_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH:0]             in_sum,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH:0]             out_sum,
    output logic [2:0]                 out_flags,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = WIDTH + 4;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    logic [EW-1:0]  mem [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic [EW-1:0]  head_q, head_d;
    logic [2:0]     in_flags;
    logic [EW-1:0]  in_entry;
    logic           push, pop;
    fifo_state_e    state;

    adder_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .sum_i   (in_sum),
        .flags_o (in_flags)
    );

    assign in_entry = {in_flags, in_sum};

    always_comb begin
        if (level_q == '0)
            state = FIFO_EMPTY;
        else if (level_q == LEVEL_FULL)
            state = FIFO_FULL;
        else
            state = FIFO_PARTIAL;
    end

    assign in_ready  = (state != FIFO_FULL);
    assign out_valid = (state != FIFO_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        head_d   = head_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            // The next head may be the slot being written this cycle (empty, or last
            // entry popped), which the array cannot return yet: forward it.
            if (level_d != '0) begin
                if (push && (wr_ptr_q == rd_ptr_d))
                    head_d = in_entry;
                else
                    head_d = mem[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr_q] <= in_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    assign out_sum   = head_q[WIDTH:0];
    assign out_flags = head_q[EW-1 -: 3];
    assign level     = level_q;

endmodule

// File: tb/tb_adder_result_stage.sv
// Self-checking bench for adder_result_stage: directed vectors, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_adder_result_stage;
    import adder_result_stage_pkg::*;

    localparam int W = 8;
    localparam int D = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [W:0]         in_sum;
    logic               out_valid;
    logic               out_ready;
    logic [W:0]         out_sum;
    logic [2:0]         out_flags;
    logic [$clog2(D):0] level;

    int checks = 0;
    int errors = 0;
    logic [W:0] model_q [$];

    typedef struct {
        logic [W:0] sum;
        logic [2:0] flags;
    } vec_t;

    always #5 clk = ~clk;

    adder_result_stage #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_flags (out_flags),
        .level     (level)
    );

    // Flags from plain arithmetic on the sum value: {zero, neg, carry}
    function automatic logic [2:0] ref_flags(input logic [W:0] s);
        int v;
        int low;
        v = int'(s);
        low = v % (1 << W);
        ref_flags = {low == 0, low >= (1 << (W - 1)), v >= (1 << W)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(model_q.size() != 0));
        chk({tag, " in_ready"},  32'(in_ready),  32'(model_q.size() != D));
        chk({tag, " level"},     32'(level),     32'(model_q.size()));
        if (model_q.size() != 0) begin
            chk({tag, " out_sum"},   32'(out_sum),   32'(model_q[0]));
            chk({tag, " out_flags"}, 32'(out_flags), 32'(ref_flags(model_q[0])));
        end
    endtask

    // One clock: drive, check at the falling edge, then advance the model on the rising edge.
    task automatic cycle(input logic iv, input logic [W:0] s, input logic ordy,
                         input logic fl, input string tag, output logic acc);
        logic push;
        logic pop;
        in_valid  = iv;
        in_sum    = s;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        check_state(tag);
        push = iv && (model_q.size() < D);
        pop  = ordy && (model_q.size() > 0);
        acc  = push && !fl;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (pop) begin
                $display("%s: pop sum=%h flags=%b level_before=%0d", tag, model_q[0],
                         ref_flags(model_q[0]), model_q.size());
                void'(model_q.pop_front());
            end
            if (push)
                model_q.push_back(s);
        end
        #1;
    endtask

    task automatic push_hold(input logic [W:0] s, input logic ordy, input string tag);
        logic acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            cycle(1'b1, s, ordy, 1'b0, tag, acc);
            n++;
        end
        if (!acc)
            chk({tag, " push accepted"}, 32'(acc), 32'd1);
    endtask

    task automatic drain(input string tag);
        logic acc;
        int n;
        n = 0;
        while (model_q.size() != 0 && n < 10) begin
            cycle(1'b0, '0, 1'b1, 1'b0, tag, acc);
            n++;
        end
        chk({tag, " drained level"}, 32'(level), 32'd0);
    endtask

    initial begin
        vec_t tbl [6];
        logic acc;
        logic [W:0] pending;

        tbl[0] = '{sum: 9'h000, flags: 3'b100};
        tbl[1] = '{sum: 9'h180, flags: 3'b011};
        tbl[2] = '{sum: 9'h07F, flags: 3'b000};
        tbl[3] = '{sum: 9'h100, flags: 3'b101};
        tbl[4] = '{sum: 9'h0FF, flags: 3'b010};
        tbl[5] = '{sum: 9'h101, flags: 3'b001};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sum = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        cycle(1'b0, '0, 1'b0, 1'b0, "reset idle", acc);
        chk("reset out_sum",   32'(out_sum),   32'd0);
        chk("reset out_flags", 32'(out_flags), 32'd0);

        for (int i = 0; i < 6; i++) begin
            push_hold(tbl[i].sum, 1'b1, "vector push");
            chk("vector out_valid", 32'(out_valid), 32'd1);
            chk("vector out_sum",   32'(out_sum),   32'(tbl[i].sum));
            chk("vector out_flags", 32'(out_flags), 32'(tbl[i].flags));
            cycle(1'b0, '0, 1'b1, 1'b0, "vector pop", acc);
        end

        for (int i = 0; i < 4; i++)
            cycle(1'b1, 9'(8'h10 + i), 1'b0, 1'b0, "fill", acc);
        chk("full level",    32'(level),    32'd4);
        chk("full in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 9'h1E5, 1'b0, 1'b0, "full hold", acc);
            chk("full push blocked", 32'(acc), 32'd0);
        end
        cycle(1'b1, 9'h1E5, 1'b1, 1'b0, "full pop", acc);
        chk("pop while full blocks push", 32'(acc), 32'd0);
        chk("in_ready after pop", 32'(in_ready), 32'd1);
        cycle(1'b1, 9'h1E5, 1'b0, 1'b0, "held push", acc);
        chk("held push accepted", 32'(acc), 32'd1);
        drain("fill drain");

        cycle(1'b1, 9'h021, 1'b0, 1'b0, "prime", acc);
        cycle(1'b1, 9'h042, 1'b0, 1'b0, "prime", acc);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 9'(9'h150 + i), 1'b1, 1'b0, "stream", acc);
            chk("stream accepted", 32'(acc), 32'd1);
            chk("stream level", 32'(level), 32'd2);
        end
        drain("stream drain");

        for (int i = 0; i < 3; i++)
            cycle(1'b1, 9'(9'h0A0 + i), 1'b0, 1'b0, "pre flush", acc);
        cycle(1'b1, 9'h1AA, 1'b1, 1'b1, "flush", acc);
        chk("flush level",     32'(level),     32'd0);
        chk("flush out_valid", 32'(out_valid), 32'd0);
        chk("flush in_ready",  32'(in_ready),  32'd1);
        cycle(1'b1, 9'h055, 1'b0, 1'b0, "post flush push", acc);
        chk("post flush out_sum", 32'(out_sum), 32'h055);
        chk("post flush level",   32'(level),   32'd1);
        drain("flush drain");

        for (int i = 0; i < 3; i++)
            cycle(1'b1, 9'(9'h1C0 + i), 1'b0, 1'b0, "pre reset", acc);
        #1 rst = 1'b1;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst in_ready",  32'(in_ready),  32'd1);
        chk("async rst level",     32'(level),     32'd0);
        chk("async rst out_sum",   32'(out_sum),   32'd0);
        chk("async rst out_flags", 32'(out_flags), 32'd0);
        #1 rst = 1'b0;
        model_q.delete();
        cycle(1'b1, 9'h0C3, 1'b1, 1'b0, "post reset push", acc);
        chk("post reset level",   32'(level),   32'd1);
        chk("post reset out_sum", 32'(out_sum), 32'h0C3);
        cycle(1'b0, '0, 1'b1, 1'b0, "post reset pop", acc);
        chk("post reset empty", 32'(out_valid), 32'd0);

        pending = 9'($urandom);
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, pending, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 39) == 0, "random", acc);
            if (acc)
                pending = 9'($urandom);
        end
        drain("random drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_result_stage.md
# adder_result_stage

Registered result buffer sitting directly downstream of the Brent–Kung adder. It captures the adder's `INPUTSIZE+1`-bit sum whenever the upstream producer asserts valid. It derives zero, carry and sign flags, and holds the entries in a small FIFO. It presents them to the consumer over a valid/ready handshake, so the combinational adder path never has to meet a downstream stall in the same cycle.

## Interface
Parameters:
- `WIDTH`, default `` `INPUTSIZE ``: adder operand width; the stored sum is `WIDTH+1` bits.
- `DEPTH`, default `` `RESULT_FIFO_DEPTH `` (4): number of FIFO entries; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous clear of all entries.
- `in_valid`  in  1  adder result `in_sum` is valid this cycle.
- `in_ready`  out  1  a slot is free; a push happens when `in_valid && in_ready`.
- `in_sum`  in  `WIDTH+1`  adder output S.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  consumer accepts the head entry; a pop happens when `out_valid && out_ready`.
- `out_sum`  out  `WIDTH+1`  head entry sum.
- `out_flags`  out  3  head flags `{zero, neg, carry}`.
- `level`  out  `$clog2(DEPTH)+1`  current occupancy.

## Operation
Flags are computed at push time and stored alongside the sum:
- `carry` = `in_sum[WIDTH]`.
- `neg` = `in_sum[WIDTH-1]`.
- `zero` = (`in_sum[WIDTH-1:0] == 0`).

Storage and pointers:
- Storage is `DEPTH` entries of `WIDTH+4` bits.
- `wr_ptr` and `rd_ptr` are `$clog2(DEPTH)` bits and wrap modulo `DEPTH` with no special case.
- `level` tracks occupancy.

Handshake outputs:
- `in_ready` = (`level != DEPTH`).
- `out_valid` = (`level != 0`).
- `out_sum` and `out_flags` read the entry at `rd_ptr`. When the FIFO is empty they hold the last-read entry; these values are don't-care while `out_valid` is 0.

Per-cycle `level` update:
- Push only: `level` +1.
- Pop only: `level` −1.
- Push and pop together (possible only when 0 < `level` < `DEPTH`): `level` unchanged, both pointers advance.
- `flush`: `level`, `wr_ptr` and `rd_ptr` all go to 0. `flush` has priority over a push or pop in the same cycle; that push is discarded.

State:
- The control is effectively an EMPTY / PARTIAL / FULL state machine derived from `level`; no separate state register.
- EMPTY → PARTIAL on push.
- PARTIAL → FULL on push-only when `level == DEPTH-1`.
- FULL → PARTIAL on pop.
- PARTIAL → EMPTY on pop-only when `level == 1`.
- Any state → EMPTY on `flush`.

Reset values (asynchronous): `level`=0, pointers=0, `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_flags`=0. Storage contents are not reset.

## Timing
- Push in cycle N makes the entry visible with `out_valid`=1 in cycle N+1. There is no same-cycle bypass, so minimum latency is 1.
- Back-to-back pushes and pops sustain one result per cycle when `level` is between 1 and `DEPTH-1`.
- `in_ready` depends only on registered `level`, never combinationally on `out_ready`. When FULL, a pop in cycle N raises `in_ready` in cycle N+1.
- Push attempted while FULL (`in_valid`=1, `in_ready`=0): no state change. The producer holds `in_sum` until accepted.
- Reset asserted mid-stream: all entries are discarded immediately. After `rst` deasserts, the first push appears at the output one cycle later.
- Flush in cycle N: `out_valid`=0 and `in_ready`=1 in cycle N+1.

## Structure
- `define.v` holds `INPUTSIZE`, `GROUPSIZE` and the new `RESULT_FIFO_DEPTH` (4), plus the flag-bit index constants `FLAG_CARRY`=0, `FLAG_NEG`=1, `FLAG_ZERO`=2.
- One sub-module, `adder_flag_gen`: combinational, `in_sum` → 3 flag bits. It is reusable by later stages that consume unbuffered sums.
- Storage, pointers and `level` stay in `adder_result_stage`.

## Test plan
- Reset then idle: `out_valid`=0, `in_ready`=1, `level`=0, `out_sum`=0, `out_flags`=0.
- `WIDTH`=8. Push 9'h000, 9'h180, 9'h07F, each held until accepted, with `out_ready`=1. Expected output one cycle after each push: flags 3'b100, 3'b011, 3'b000 respectively, in order.
- Fill with `out_ready`=0: after 4 pushes `level`=4 and `in_ready`=0. A 5th push while full does not change state. One pop raises `in_ready` the following cycle, and the held 5th value enters next.
- Simultaneous push and pop at `level`=2 for 10 cycles: `level` stays 2, pointers wrap past 3→0, and output order matches input order.
- `flush` asserted together with a push at `level`=3: next cycle `level`=0 and `out_valid`=0, and the flushed push never appears at the output.
- `rst` pulsed asynchronously between edges at `level`=3: outputs return to reset values immediately. The first post-reset push is seen alone at the output.
